// File: rtl/horner_frame_tx.sv
// rtl/horner_frame_tx.sv - AXI4-Stream job frame transmitter for the Horner core
module horner_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ORI_NUM    = 8,
  parameter int INT_NUM    = 35,
  parameter int LAY_NUM    = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        m00_axis_aclk,
  input  logic                        m00_axis_aresetn,
  input  logic                        start,
  input  logic [LANES*DATA_WIDTH-1:0] cal_num,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] mem_rd_data,
  output logic [LANES*DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  input  logic                        m00_axis_tready,
  output logic                        m00_axis_tlast
);

  localparam int W          = LANES * DATA_WIDTH;
  localparam int WEIGHT_NUM = 3 * ORI_NUM + INT_NUM - LAY_NUM + 3;
  localparam int MAT_NUM    = 12;
  localparam int VEC_NUM    = ORI_NUM + INT_NUM + LAY_NUM + 3;
  localparam int FRAME_LEN  = 1 + WEIGHT_NUM + MAT_NUM + VEC_NUM;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 2);
  localparam logic [ADDR_WIDTH-1:0] WGT_END   = ADDR_WIDTH'(WEIGHT_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] MAT_END   = ADDR_WIDTH'(MAT_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] VEC_END   = ADDR_WIDTH'(VEC_NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY, ST_DRAIN} state_t;
  typedef enum logic [1:0] {SEC_HDR, SEC_WGT, SEC_MAT, SEC_VEC} sec_t;

  state_t                state_q, state_d;
  sec_t                  sec_q, sec_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [W-1:0]          e0_q, e0_d;
  logic [W-1:0]          e1_q, e1_d;
  logic                  done_q;

  logic         pop;
  logic         last_hs;
  logic         hdr_push;
  logic         push;
  logic [W-1:0] din;
  logic         rd_issue;
  logic         can_rd;
  logic [2:0]   used;

  assign m00_axis_tvalid = (occ_q != 2'd0);
  assign m00_axis_tdata  = e0_q;
  assign m00_axis_tlast  = m00_axis_tvalid && (sec_q == SEC_VEC) && (cnt_q == VEC_END);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign mem_rd_en       = rd_issue;
  assign mem_rd_addr     = rd_addr_q;

  assign pop     = m00_axis_tvalid && m00_axis_tready;
  assign last_hs = pop && m00_axis_tlast;

  // A read may issue only if its word is guaranteed a FIFO slot when it
  // lands; a beat leaving this cycle frees one slot in advance.
  assign used   = {1'b0, occ_q} + {2'b00, inflight_q};
  assign can_rd = pop ? (used < 3'd3) : (used < 3'd2);

  // Next-state and read issue; address 0 is fetched on the accepted start so
  // the first buffer word lands right behind the header.
  always_comb begin
    state_d   = state_q;
    rd_issue  = 1'b0;
    hdr_push  = 1'b0;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && m00_axis_aresetn) begin
          hdr_push = 1'b1;
          rd_issue = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        rd_issue = can_rd;
        if (pop) state_d = ST_BODY;
        if (rd_issue && (rd_addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      end
      ST_BODY: begin
        rd_issue = can_rd;
        if (rd_issue && (rd_addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The address parks on the final word so it never points past the frame.
    if (rd_issue && (rd_addr_q != LAST_ADDR)) rd_addr_d = rd_addr_q + 1'b1;
    if ((state_q == ST_DRAIN) && last_hs) rd_addr_d = '0;
  end

  assign push = hdr_push || inflight_q;
  assign din  = hdr_push ? cal_num : mem_rd_data;

  // Two-entry output FIFO: e0 is the presented beat, e1 the skid slot.
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = din;
        else               e1_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Section position of the presented beat; it drives tlast.
  always_comb begin
    sec_d = sec_q;
    cnt_d = cnt_q;
    if (pop) begin
      unique case (sec_q)
        SEC_HDR: begin
          sec_d = SEC_WGT;
          cnt_d = '0;
        end
        SEC_WGT: begin
          if (cnt_q == WGT_END) begin
            sec_d = SEC_MAT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SEC_MAT: begin
          if (cnt_q == MAT_END) begin
            sec_d = SEC_VEC;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SEC_VEC: begin
          if (cnt_q == VEC_END) begin
            sec_d = SEC_HDR;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          sec_d = SEC_HDR;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State, FIFO and counters; reset abandons any partial frame.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q    <= ST_IDLE;
      sec_q      <= SEC_HDR;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_issue;
      occ_q      <= occ_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      done_q     <= last_hs;
    end
  end

endmodule

// File: tb/tb_horner_frame_tx.sv
// tb/tb_horner_frame_tx.sv - self-checking bench for horner_frame_tx
module tb_horner_frame_tx;

  localparam int FL = 121;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [63:0] cal_num;
  logic        busy, done;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [63:0] mem_rd_data = '0;
  logic [63:0] tdata;
  logic        tvalid, tready, tlast;

  always #5 clk = ~clk;

  horner_frame_tx dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rstn),
    .start            (start),
    .cal_num          (cal_num),
    .busy             (busy),
    .done             (done),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .m00_axis_tdata   (tdata),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tready  (tready),
    .m00_axis_tlast   (tlast)
  );

  logic [63:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 64'(i + 1);

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [63:0] cal;
    int          mode;
    int          hdr_wait;
    int          exp_beats;
    int          exp_dones;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   beats = 0;
  int   dones = 0;
  int   exp_done_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic        stall_q;
    logic [63:0] stall_data;
    logic        stall_last;
    exp_t        e;
    stall_q = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_q = 1'b0;
      end else begin
        if (mem_rd_en) begin
          total++;
          if (mem_rd_addr > 8'd119) begin
            bad++;
            $display("FAIL rd_addr_max: got %0d limit 119", mem_rd_addr);
          end
        end
        if (stall_q) begin
          chk("stall_tvalid", 64'(tvalid), 64'd1);
          chk("stall_tdata", tdata, stall_data);
          chk("stall_tlast", 64'(tlast), 64'(stall_last));
        end
        if (done) begin
          dones++;
          chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
          chk("done_busy", 64'(busy), 64'd0);
          chk("done_tvalid", 64'(tvalid), 64'd0);
        end
        if (tvalid && tready) begin
          beats++;
          chk("beat_busy", 64'(busy), 64'd1);
          if (sb.size() == 0) begin
            chk("extra_beat", tdata, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("beat_data", tdata, e.data);
            chk("beat_last", 64'(tlast), 64'(e.last));
            if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
          end
          if (tlast) exp_done_cyc = cyc + 1;
        end
        stall_q    = tvalid && !tready;
        stall_data = tdata;
        stall_last = tlast;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive an accepted start in the current cycle and queue the whole frame.
  task automatic drive_start(input logic [63:0] cal, input int mode, input int hw, output int s);
    s       = cyc;
    start   = 1'b1;
    cal_num = cal;
    tready  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    sb.push_back('{cal, 1'b0, (mode == 1) ? -1 : s + 1 + hw});
    for (int j = 1; j < FL; j++)
      sb.push_back('{64'(j), (j == FL - 1), (mode == 1) ? -1 : s + 1 + hw + j});
  endtask

  task automatic run_until_done(input int s, input int mode, input int hw,
                                input int x1, input int x2);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 1000) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      case (mode)
        0:       tready = 1'b1;
        1:       tready = 1'($urandom_range(0, 1));
        default: tready = (cyc >= s + 1 + hw);
      endcase
      if (cyc == x1 || cyc == x2) begin
        chk("busy_at_extra_start", 64'(busy), 64'd1);
        start   = 1'b1;
        cal_num = 64'hDEAD;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(tlast), 64'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
  endtask

  initial begin : main
    vec_t vt[4];
    int   s, b0, d0, n;

    vt[0] = '{64'd3, 0, 0, FL, 1};
    vt[1] = '{64'd3, 1, 0, FL, 1};
    vt[2] = '{64'd3, 2, 20, FL, 1};
    vt[3] = '{64'hA5A5_0000_FFFF_1234, 0, 0, FL, 1};

    void'($urandom(32'd12345));
    rstn    = 1'b0;
    start   = 1'b0;
    tready  = 1'b0;
    cal_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      b0 = beats;
      d0 = dones;
      drive_start(vt[i].cal, vt[i].mode, vt[i].hdr_wait, s);
      run_until_done(s, vt[i].mode, vt[i].hdr_wait, -1, -1);
      idle(3);
      chk("vec_beats", 64'(beats - b0), 64'(vt[i].exp_beats));
      chk("vec_dones", 64'(dones - d0), 64'(vt[i].exp_dones));
      chk("vec_sb_empty", 64'(sb.size()), 64'd0);
    end

    // Starts while busy are ignored.
    b0 = beats;
    d0 = dones;
    drive_start(64'd7, 0, 0, s);
    run_until_done(s, 0, 0, s + 11, s + 61);
    idle(5);
    chk("ign_beats", 64'(beats - b0), 64'(FL));
    chk("ign_dones", 64'(dones - d0), 64'd1);
    chk("ign_busy", 64'(busy), 64'd0);

    // Reset in the middle of a frame, then a fresh frame.
    b0 = beats;
    d0 = dones;
    drive_start(64'd3, 0, 0, s);
    n = 0;
    while (cyc < s + 41 && n < 200) begin
      @(posedge clk); #1;
      start  = 1'b0;
      tready = 1'b1;
      n++;
    end
    rstn = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("midrst");
    chk("beats_before_reset", 64'(beats - b0), 64'd40);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_hold_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    idle(1);
    drive_start(64'd3, 0, 0, s);
    run_until_done(s, 0, 0, -1, -1);
    idle(3);
    chk("post_rst_beats", 64'(beats - b0), 64'(40 + FL));
    chk("post_rst_dones", 64'(dones - d0), 64'd1);

    // Three frames back to back, each started on the previous done cycle.
    b0 = beats;
    d0 = dones;
    for (int f = 0; f < 3; f++) begin
      drive_start(64'(3 + f), 0, 0, s);
      run_until_done(s, 0, 0, -1, -1);
    end
    idle(3);
    chk("b2b_beats", 64'(beats - b0), 64'(3 * FL));
    chk("b2b_dones", 64'(dones - d0), 64'd3);
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
